// File: rtl/fir_package.sv
// Shared types for the FIR job sequencer: FSM state, job descriptor,
// per-stream launch configuration and the word-count helper.
package fir_package;

  localparam int FIR_ADDR_WIDTH = 32;
  localparam int FIR_LEN_WIDTH  = 16;
  localparam int FIR_MAX_TAPS   = 64;

  typedef enum logic [2:0] {
    FIR_SEQ_IDLE   = 3'd0,
    FIR_SEQ_CLEAR  = 3'd1,
    FIR_SEQ_LAUNCH = 3'd2,
    FIR_SEQ_RUN    = 3'd3,
    FIR_SEQ_DONE   = 3'd4
  } fir_seq_state_t;

  typedef struct packed {
    logic [FIR_ADDR_WIDTH-1:0] x_base;
    logic [FIR_ADDR_WIDTH-1:0] h_base;
    logic [FIR_ADDR_WIDTH-1:0] y_base;
    logic [FIR_LEN_WIDTH-1:0]  nb_samples;
    logic [FIR_LEN_WIDTH-1:0]  nb_taps;
  } fir_job_t;

  typedef struct packed {
    logic [FIR_ADDR_WIDTH-1:0] base;
    logic [FIR_LEN_WIDTH-1:0]  words;
  } fir_seq_stream_cfg_t;

  // ceil(count / 2**shift) evaluated in LEN+1 bits, truncated to LEN bits.
  function automatic logic [FIR_LEN_WIDTH-1:0] fir_ceil_words(
    input logic [FIR_LEN_WIDTH:0] count,
    input int unsigned            shift
  );
    logic [FIR_LEN_WIDTH:0] round_up;
    logic [FIR_LEN_WIDTH:0] sum;
    round_up = ((FIR_LEN_WIDTH+1)'(1) << shift) - (FIR_LEN_WIDTH+1)'(1);
    sum      = count + round_up;
    sum      = sum >> shift;
    return sum[FIR_LEN_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/fir_seq_done_tracker.sv
// Sticky completion flags for the x source, h source and y sink.
// all_done_o already includes pulses arriving in the current cycle so a
// final done pulse is never lost on the cycle the job wraps up.
module fir_seq_done_tracker (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic set_en_i,
  input  logic x_done_i,
  input  logic h_done_i,
  input  logic y_done_i,
  output logic all_done_o
);

  logic [2:0] flags_q;
  logic [2:0] pulses;

  assign pulses     = {y_done_i, h_done_i, x_done_i} & {3{set_en_i}};
  assign all_done_o = &(flags_q | pulses);

  // Accumulate done pulses; clear has priority over any set.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      flags_q <= 3'b000;
    end else begin
      flags_q <= flags_q | pulses;
    end
  end

endmodule

// File: rtl/fir_stream_sequencer.sv
// Job-level controller for the FIR streamer: latches and validates one
// job descriptor, derives per-stream word counts, launches the x/h sources
// and y sink together, waits for all three and reports completion.
//
// Handshake: start_i is a single-cycle trigger, accepted only when busy_o=0;
// each *_done_i is a single-cycle pulse, remembered until the job ends.
// state_o exposes the FSM state for debug and checkers.
module fir_stream_sequencer
  import fir_package::*;
#(
  parameter int ADDR_WIDTH = FIR_ADDR_WIDTH,
  parameter int LEN_WIDTH  = FIR_LEN_WIDTH,
  parameter int DATA_WIDTH = 16,
  parameter int MEM_WIDTH  = 32,
  parameter int MAX_TAPS   = FIR_MAX_TAPS
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clear_i,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] x_addr_i,
  input  logic [ADDR_WIDTH-1:0] h_addr_i,
  input  logic [ADDR_WIDTH-1:0] y_addr_i,
  input  logic [LEN_WIDTH-1:0]  nb_samples_i,
  input  logic [LEN_WIDTH-1:0]  nb_taps_i,
  output logic                  x_req_start_o,
  output logic                  h_req_start_o,
  output logic                  y_req_start_o,
  output logic [ADDR_WIDTH-1:0] x_base_o,
  output logic [ADDR_WIDTH-1:0] h_base_o,
  output logic [ADDR_WIDTH-1:0] y_base_o,
  output logic [LEN_WIDTH-1:0]  x_words_o,
  output logic [LEN_WIDTH-1:0]  h_words_o,
  output logic [LEN_WIDTH-1:0]  y_words_o,
  input  logic                  x_done_i,
  input  logic                  h_done_i,
  input  logic                  y_done_i,
  output logic                  stream_clear_o,
  output logic                  stream_enable_o,
  output logic [LEN_WIDTH-1:0]  dp_nb_taps_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic [31:0]           cycles_o,
  output fir_seq_state_t        state_o
);

  // Elements per memory word is a power of two, so division is a shift.
  localparam int unsigned R_SHIFT = $clog2(MEM_WIDTH / DATA_WIDTH);

  fir_seq_state_t      state_q;
  fir_job_t            job_in;
  fir_seq_stream_cfg_t x_cfg_q, h_cfg_q, y_cfg_q;
  logic [LEN_WIDTH-1:0] taps_q;

  logic [LEN_WIDTH:0]   x_span;
  logic [LEN_WIDTH-1:0] x_words_c, h_words_c, y_words_c;
  logic                 job_valid;
  logic                 all_done;
  logic                 track_en;
  logic                 track_clear;

  assign job_in = '{
    x_base:     x_addr_i,
    h_base:     h_addr_i,
    y_base:     y_addr_i,
    nb_samples: nb_samples_i,
    nb_taps:    nb_taps_i
  };

  // x is read for N+T-1 samples so every output sees a full tap window.
  assign x_span    = {1'b0, job_in.nb_samples} + {1'b0, job_in.nb_taps}
                   - (LEN_WIDTH+1)'(1);
  assign x_words_c = fir_ceil_words(x_span, R_SHIFT);
  assign h_words_c = fir_ceil_words({1'b0, job_in.nb_taps}, R_SHIFT);
  assign y_words_c = fir_ceil_words({1'b0, job_in.nb_samples}, R_SHIFT);

  assign job_valid = (job_in.nb_samples != '0) && (job_in.nb_taps != '0)
                   && (job_in.nb_taps <= LEN_WIDTH'(MAX_TAPS));

  // Done pulses can arrive as early as the launch cycle itself.
  assign track_en    = (state_q == FIR_SEQ_LAUNCH) || (state_q == FIR_SEQ_RUN);
  assign track_clear = clear_i || (state_q == FIR_SEQ_DONE);

  fir_seq_done_tracker u_done_tracker (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clear_i    (track_clear),
    .set_en_i   (track_en),
    .x_done_i   (x_done_i),
    .h_done_i   (h_done_i),
    .y_done_i   (y_done_i),
    .all_done_o (all_done)
  );

  assign x_base_o     = x_cfg_q.base;
  assign h_base_o     = h_cfg_q.base;
  assign y_base_o     = y_cfg_q.base;
  assign x_words_o    = x_cfg_q.words;
  assign h_words_o    = h_cfg_q.words;
  assign y_words_o    = y_cfg_q.words;
  assign dp_nb_taps_o = taps_q;
  assign state_o      = state_q;

  // Job FSM with registered pulse/level outputs and the RUN cycle counter.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      state_q         <= FIR_SEQ_IDLE;
      x_cfg_q         <= '0;
      h_cfg_q         <= '0;
      y_cfg_q         <= '0;
      taps_q          <= '0;
      x_req_start_o   <= 1'b0;
      h_req_start_o   <= 1'b0;
      y_req_start_o   <= 1'b0;
      stream_clear_o  <= 1'b0;
      stream_enable_o <= 1'b0;
      busy_o          <= 1'b0;
      done_o          <= 1'b0;
      err_o           <= 1'b0;
      cycles_o        <= '0;
    end else begin
      stream_clear_o <= 1'b0;
      x_req_start_o  <= 1'b0;
      h_req_start_o  <= 1'b0;
      y_req_start_o  <= 1'b0;
      done_o         <= 1'b0;
      err_o          <= 1'b0;
      case (state_q)
        FIR_SEQ_IDLE: begin
          if (start_i) begin
            if (job_valid) begin
              x_cfg_q        <= '{base: job_in.x_base, words: x_words_c};
              h_cfg_q        <= '{base: job_in.h_base, words: h_words_c};
              y_cfg_q        <= '{base: job_in.y_base, words: y_words_c};
              taps_q         <= job_in.nb_taps;
              stream_clear_o <= 1'b1;
              busy_o         <= 1'b1;
              state_q        <= FIR_SEQ_CLEAR;
            end else begin
              err_o <= 1'b1;
            end
          end
        end
        FIR_SEQ_CLEAR: begin
          x_req_start_o   <= 1'b1;
          h_req_start_o   <= 1'b1;
          y_req_start_o   <= 1'b1;
          stream_enable_o <= 1'b1;
          cycles_o        <= '0;
          state_q         <= FIR_SEQ_LAUNCH;
        end
        FIR_SEQ_LAUNCH: begin
          state_q <= FIR_SEQ_RUN;
        end
        FIR_SEQ_RUN: begin
          if (cycles_o != '1) begin
            cycles_o <= cycles_o + 32'd1;
          end
          if (all_done) begin
            done_o          <= 1'b1;
            stream_enable_o <= 1'b0;
            state_q         <= FIR_SEQ_DONE;
          end
        end
        FIR_SEQ_DONE: begin
          busy_o  <= 1'b0;
          state_q <= FIR_SEQ_IDLE;
        end
        default: begin
          state_q <= FIR_SEQ_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fir_stream_sequencer.sv
// Bench for fir_stream_sequencer: timeline-based reference model, per-cycle
// compare process, done/cycles scoreboard, directed and random jobs.
module tb_fir_stream_sequencer;
  import fir_package::*;

  localparam int AW = 32;
  localparam int LW = 16;
  localparam int DW = 16;
  localparam int MW = 32;
  localparam int MT = 64;
  localparam int R  = MW / DW;

  logic          clk;
  logic          rst, clear, start;
  logic [AW-1:0] x_addr, h_addr, y_addr;
  logic [LW-1:0] nb_samples, nb_taps;
  logic          x_req, h_req, y_req;
  logic [AW-1:0] x_base, h_base, y_base;
  logic [LW-1:0] x_words, h_words, y_words;
  logic          x_done, h_done, y_done;
  logic          stream_clear, stream_enable;
  logic [LW-1:0] dp_nb_taps;
  logic          busy, done, err;
  logic [31:0]   cycles;
  fir_seq_state_t state_dbg;

  fir_stream_sequencer #(
    .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .DATA_WIDTH(DW), .MEM_WIDTH(MW), .MAX_TAPS(MT)
  ) dut (
    .clk_i(clk), .rst_i(rst), .clear_i(clear), .start_i(start),
    .x_addr_i(x_addr), .h_addr_i(h_addr), .y_addr_i(y_addr),
    .nb_samples_i(nb_samples), .nb_taps_i(nb_taps),
    .x_req_start_o(x_req), .h_req_start_o(h_req), .y_req_start_o(y_req),
    .x_base_o(x_base), .h_base_o(h_base), .y_base_o(y_base),
    .x_words_o(x_words), .h_words_o(h_words), .y_words_o(y_words),
    .x_done_i(x_done), .h_done_i(h_done), .y_done_i(y_done),
    .stream_clear_o(stream_clear), .stream_enable_o(stream_enable),
    .dp_nb_taps_o(dp_nb_taps), .busy_o(busy), .done_o(done), .err_o(err),
    .cycles_o(cycles), .state_o(state_dbg)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- counters / check ----------------
  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int n_done_seen = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // A job accepted at edge acc_t: clear pulse after acc_t, launch after
  // acc_t+1; done pulses count from the launch cycle on; the job finishes at
  // the first RUN edge (>= acc_t+3) by which all three were seen.
  bit          m_active = 1'b0;
  bit          m_has_job = 1'b0;
  int          acc_t = -100;
  int          fin_t = -1;
  int          err_t = -100;
  bit [2:0]    seen;
  logic [31:0] m_hold = '0;
  logic [AW-1:0] e_xb = '0, e_hb = '0, e_yb = '0;
  logic [LW-1:0] e_xw = '0, e_hw = '0, e_yw = '0, e_taps = '0;

  function automatic logic [LW-1:0] ceil_words(input int v);
    int s;
    s = ((v & 32'h1ffff) + R - 1) & 32'h1ffff;
    return LW'(s / R);
  endfunction

  function automatic logic [31:0] exp_cycles();
    int last, v;
    if (!m_has_job || cyc < acc_t + 1) return m_hold;
    last = (fin_t >= 0 && fin_t < cyc) ? fin_t : cyc;
    v = last - (acc_t + 2);
    return (v < 0) ? 32'd0 : 32'(v);
  endfunction

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst || clear) begin
      m_active = 0; m_has_job = 0; acc_t = -100; fin_t = -1; err_t = -100;
      seen = '0; m_hold = '0;
      e_xb = '0; e_hb = '0; e_yb = '0; e_xw = '0; e_hw = '0; e_yw = '0; e_taps = '0;
      exp_q.delete();
    end else if (!m_active) begin
      if (start) begin
        if (nb_samples != 0 && nb_taps != 0 && int'(nb_taps) <= MT) begin
          m_hold = exp_cycles();
          m_has_job = 1; m_active = 1; acc_t = cyc; fin_t = -1; seen = '0;
          e_xb = x_addr; e_hb = h_addr; e_yb = y_addr; e_taps = nb_taps;
          e_xw = ceil_words(int'(nb_samples) + int'(nb_taps) - 1);
          e_hw = ceil_words(int'(nb_taps));
          e_yw = ceil_words(int'(nb_samples));
        end else begin
          err_t = cyc;
        end
      end
    end else begin
      if (fin_t < 0 && cyc >= acc_t + 2) begin
        seen = seen | {y_done, h_done, x_done};
        if (seen == 3'b111) begin
          fin_t = (cyc > acc_t + 3) ? cyc : acc_t + 3;
          exp_q.push_back(32'(fin_t - (acc_t + 2)));
        end
      end
      if (fin_t >= 0 && cyc == fin_t + 1) m_active = 0;
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (cyc >= 1) begin
      check("busy", busy, m_active);
      check("stream_clear", stream_clear, m_active && cyc == acc_t);
      check("x_req", x_req, m_active && cyc == acc_t + 1);
      check("h_req", h_req, m_active && cyc == acc_t + 1);
      check("y_req", y_req, m_active && cyc == acc_t + 1);
      check("stream_enable", stream_enable,
            m_active && cyc >= acc_t + 1 && (fin_t < 0 || cyc < fin_t));
      check("done", done, m_active && fin_t >= 0 && cyc == fin_t);
      check("err", err, cyc == err_t);
      check("cycles", cycles, exp_cycles());
      check("x_base", x_base, e_xb);
      check("h_base", h_base, e_hb);
      check("y_base", y_base, e_yb);
      check("x_words", x_words, e_xw);
      check("h_words", h_words, e_hw);
      check("y_words", y_words, e_yw);
      check("dp_nb_taps", dp_nb_taps, e_taps);
      if (done === 1'b1) begin
        n_done_seen++;
        if (exp_q.size() == 0) check("done_unexpected", done, 1'b0);
        else check("cycles_at_done", cycles, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input int n, input int t);
    x_addr = $urandom; h_addr = $urandom; y_addr = $urandom;
    nb_samples = LW'(n); nb_taps = LW'(t);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (busy !== 1'b1) break;
      tick();
    end
    check("busy_timeout", busy, 1'b0);
  endtask

  // Called in the CLEAR cycle; offsets are relative to the launch cycle.
  task automatic play_dones(input int dx, input int dh, input int dy, input bit poke);
    int m;
    tick();
    check("req_in_launch", {x_req, h_req, y_req}, 3'b111);
    m = (dx > dh) ? dx : dh;
    m = (dy > m) ? dy : m;
    for (int k = 0; k <= m; k++) begin
      x_done = (k == dx); h_done = (k == dh); y_done = (k == dy);
      if (poke && k == 1) begin
        start = 1'b1;
        nb_samples = LW'($urandom_range(1, 50));
        nb_taps = LW'($urandom_range(1, 64));
        x_addr = $urandom;
      end
      tick();
      start = 1'b0;
    end
    x_done = 0; h_done = 0; y_done = 0;
    wait_idle(20);
  endtask

  task automatic bad_job(input int n, input int t);
    start_job(n, t);
    check("err_pulse", err, 1'b1);
    check("busy_after_bad", busy, 1'b0);
    tick();
    check("err_single", err, 1'b0);
    tick();
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  int exp_dones = 0;

  initial begin
    rst = 1; clear = 0; start = 0;
    x_addr = '0; h_addr = '0; y_addr = '0; nb_samples = '0; nb_taps = '0;
    x_done = 0; h_done = 0; y_done = 0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", busy, 1'b0);
    check("reset_cycles", cycles, 32'd0);
    rst = 0;
    tick();

    // Basic job with literal expectations.
    start_job(8, 4);
    check("t1_x_words", x_words, 16'd6);
    check("t1_h_words", h_words, 16'd2);
    check("t1_y_words", y_words, 16'd4);
    check("t1_clear", stream_clear, 1'b1);
    play_dones(20, 25, 30, 0);
    exp_dones++;
    check("t1_cycles", cycles, 32'd30);
    check("t1_done_count", n_done_seen, exp_dones);

    // Odd sizes.
    start_job(5, 3);
    check("t2_x_words", x_words, 16'd4);
    check("t2_h_words", h_words, 16'd2);
    check("t2_y_words", y_words, 16'd3);
    play_dones(3, 1, 7, 0);
    exp_dones++;
    check("t2_cycles", cycles, 32'd7);

    // Invalid jobs.
    bad_job(0, 4);
    bad_job(4, 0);
    bad_job(4, 65);
    check("t3_x_words_kept", x_words, 16'd4);

    // Simultaneous and early done pulses.
    start_job(16, 64);
    play_dones(5, 5, 5, 0);
    exp_dones++;
    start_job(3, 1);
    play_dones(0, 4, 6, 0);
    exp_dones++;
    start_job(1, 1);
    play_dones(0, 0, 0, 0);
    exp_dones++;
    check("t4_cycles_min", cycles, 32'd1);
    check("t4_done_count", n_done_seen, exp_dones);

    // Start during RUN is ignored.
    start_job(9, 7);
    play_dones(6, 9, 12, 1);
    exp_dones++;
    check("t5_x_words", x_words, 16'd8);
    check("t5_taps", dp_nb_taps, 16'd7);
    check("t5_done_count", n_done_seen, exp_dones);

    // Clear mid-run with two flags set.
    start_job(10, 6);
    tick();
    for (int k = 0; k <= 5; k++) begin
      x_done = (k == 2); h_done = (k == 3); clear = (k == 5);
      tick();
    end
    x_done = 0; h_done = 0; clear = 0;
    check("t6_busy", busy, 1'b0);
    check("t6_x_words", x_words, 16'd0);
    check("t6_enable", stream_enable, 1'b0);
    start_job(7, 2);
    play_dones(10, 12, 2, 0);
    exp_dones++;
    check("t6_cycles", cycles, 32'd12);
    check("t6_done_count", n_done_seen, exp_dones);

    // Random jobs.
    for (int j = 0; j < 30; j++) begin
      if ($urandom_range(0, 5) == 0) begin
        case ($urandom_range(0, 2))
          0: bad_job(0, $urandom_range(1, 64));
          1: bad_job($urandom_range(1, 40), 0);
          default: bad_job($urandom_range(1, 40), $urandom_range(65, 90));
        endcase
      end else begin
        start_job($urandom_range(1, 40), $urandom_range(1, MT));
        play_dones($urandom_range(0, 25), $urandom_range(0, 25),
                   $urandom_range(0, 25), 1'($urandom_range(0, 1)));
        exp_dones++;
      end
      tick();
    end
    check("rand_done_count", n_done_seen, exp_dones);

    repeat (3) tick();
    check("exp_q_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
